// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch front end. It walks a sequential fetch PC, requests one
// word at a time from instruction memory over a req/ack handshake, buffers the
// returned words in a small FIFO and presents the FIFO head to decode over a
// valid/ready handshake. Taken jumps/branches from execute restart fetch at a
// new PC and flush everything already buffered.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  fetch PC loaded on reset (word aligned)
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous reset, active low
//   imem_req        fetch request, held until imem_ack
//   imem_addr       word-aligned fetch address, stable while imem_req is high
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      fetched instruction word
//   redirect_valid  restart fetch at redirect_pc (flushes the FIFO)
//   redirect_pc     new fetch PC, bits [1:0] ignored
//   instr_valid     FIFO head valid
//   instr_ready     decode consumes the head when instr_valid is also high
//   instr           head instruction word
//   instr_pc        head instruction address
//   op_code         instr[31:26], for the control unit
//   head_is_jump    (FETCH_PREDECODE_EN only) head op_code is 6'h2 or 6'h3
//   head_is_branch  (FETCH_PREDECODE_EN only) head op_code is 6'h4 or 6'h5
//
// Configuration macro
//   FETCH_PREDECODE_EN  when defined, each FIFO entry carries two predecode
//                       bits computed at push time and the two head_is_*
//                       outputs exist; when undefined they are absent.
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  op_code
`ifdef FETCH_PREDECODE_EN
    ,
    output logic        head_is_jump,
    output logic        head_is_branch
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef FETCH_PREDECODE_EN
    localparam int EW = 66;
`else
    localparam int EW = 64;
`endif

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   drain_addr;
    logic [31:0]   redirect_target;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [EW-1:0] push_entry;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   last_instr;
    logic [31:0]   last_pc;
    logic          push;
    logic          pop;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign head            = mem[rd_ptr];
    assign instr_valid     = (count != '0);

    // A word is kept only when it arrives for a live request; data returned
    // in DRAIN or alongside a redirect belongs to the abandoned path.
    // A redirect also kills a concurrent pop since the head is being flushed.
    always_comb begin
        push = (state == ST_REQ) && imem_ack && !redirect_valid;
        pop  = instr_valid && instr_ready && !redirect_valid;
    end

`ifdef FETCH_PREDECODE_EN
    always_comb begin
        push_entry = {(imem_rdata[31:26] == 6'h02) || (imem_rdata[31:26] == 6'h03),
                      (imem_rdata[31:26] == 6'h04) || (imem_rdata[31:26] == 6'h05),
                      fetch_pc, imem_rdata};
    end
`else
    always_comb begin
        push_entry = {fetch_pc, imem_rdata};
    end
`endif

    // Next-state logic. Free space is judged on the current count only, so a
    // pop in the same cycle frees its slot for the following cycle; staying in
    // REQ after a push needs one more free slot for the next in-flight word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!redirect_valid && (count != FULL_CNT)) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid || (count >= LAST_CNT)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end else if (redirect_valid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state, fetch PC and FIFO bookkeeping. A redirect wins over any
    // push or pop in the same cycle and empties the FIFO on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            state <= state_nxt;

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            // The abandoned request keeps its address on the bus until acked
            if ((state == ST_REQ) && redirect_valid && !imem_ack) begin
                drain_addr <= fetch_pc;
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + (AW+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (AW+1)'(1);
                end
            end

            // Remember the last presented head so outputs hold while empty
            if (instr_valid) begin
                last_instr <= head[31:0];
                last_pc    <= head[63:32];
            end
        end
    end

    // FIFO storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;
    assign instr     = instr_valid ? head[31:0]  : last_instr;
    assign instr_pc  = instr_valid ? head[63:32] : last_pc;
    assign op_code   = instr[31:26];

`ifdef FETCH_PREDECODE_EN
    assign head_is_jump   = instr_valid && head[65];
    assign head_is_branch = instr_valid && head[64];
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Self-checking bench for instr_fetch_queue. A negedge monitor keeps a
// scoreboard: every accepted memory word is queued with the address the bench
// expects, and every decode handshake pops and compares. Scenario tasks add
// their own directed checks. A second instance covers a RESET_PC near the top
// of the address space. Honours FETCH_PREDECODE_EN.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  op_code;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [5:0]  w_op;

`ifdef FETCH_PREDECODE_EN
    logic head_is_jump, head_is_branch;
    logic w_jump, w_branch;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_addr;
    logic [31:0] model_drain_addr;
    bit          draining;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op_code        (op_code)
`ifdef FETCH_PREDECODE_EN
        ,
        .head_is_jump   (head_is_jump),
        .head_is_branch (head_is_branch)
`endif
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_ack),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (w_valid),
        .instr_ready    (w_ready),
        .instr          (w_instr),
        .instr_pc       (w_instr_pc),
        .op_code        (w_op)
`ifdef FETCH_PREDECODE_EN
        ,
        .head_is_jump   (w_jump),
        .head_is_branch (w_branch)
`endif
    );

    // Memory contents: the first two words are a jal and a beq, the rest are
    // address-derived so instr and instr_pc never coincide.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0C00_0010;
        if (a == 32'h4) return 32'h1000_0004;
        return a ^ 32'h5A00_0000;
    endfunction

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_addr = 32'h0;
            draining   = 1'b0;
        end else begin
            if (instr_valid && instr_ready && !redirect_valid) begin : pop_blk
                exp_t e;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_unexpected instr_pc=%h with empty scoreboard", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (instr_pc !== e.pc) begin
                        errors++;
                        $display("[TB] FAIL sb_instr_pc got %h exp %h", instr_pc, e.pc);
                    end
                    checks++;
                    if (instr !== e.word) begin
                        errors++;
                        $display("[TB] FAIL sb_instr got %h exp %h", instr, e.word);
                    end
                    checks++;
                    if (op_code !== e.word[31:26]) begin
                        errors++;
                        $display("[TB] FAIL sb_op_code got %h exp %h", op_code, e.word[31:26]);
                    end
`ifdef FETCH_PREDECODE_EN
                    checks++;
                    if (head_is_jump !== (e.word[31:26] == 6'h2 || e.word[31:26] == 6'h3)) begin
                        errors++;
                        $display("[TB] FAIL sb_head_is_jump got %b for word %h", head_is_jump, e.word);
                    end
                    checks++;
                    if (head_is_branch !== (e.word[31:26] == 6'h4 || e.word[31:26] == 6'h5)) begin
                        errors++;
                        $display("[TB] FAIL sb_head_is_branch got %b for word %h", head_is_branch, e.word);
                    end
`endif
                end
            end
`ifdef FETCH_PREDECODE_EN
            if (!instr_valid) begin
                checks++;
                if ({head_is_jump, head_is_branch} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL flags_when_empty got %b%b exp 00", head_is_jump, head_is_branch);
                end
            end
`endif
            if (imem_req && imem_ack) begin
                checks++;
                if (imem_addr !== (draining ? model_drain_addr : model_addr)) begin
                    errors++;
                    $display("[TB] FAIL sb_imem_addr got %h exp %h", imem_addr,
                             draining ? model_drain_addr : model_addr);
                end
                if (draining) begin
                    draining = 1'b0;
                end else if (!redirect_valid) begin
                    exp_q.push_back('{pc: model_addr, word: imem_rdata});
                    model_addr = model_addr + 32'd4;
                end
            end else if (redirect_valid && imem_req && !draining) begin
                draining         = 1'b1;
                model_drain_addr = model_addr;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_addr = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    // ack_mode: 0 no ack, 1 ack whenever requested, 2 ack regardless of request
    task automatic applyStimulus(input int ack_mode, input logic ready,
                                 input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #2;
        instr_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rdata     = rdata_of(imem_addr);
        imem_ack       = (ack_mode == 2) || ((ack_mode == 1) && imem_req);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr_pc got %h exp 0", instr_pc); end
        checks++; if (op_code !== 6'h0) begin errors++; $display("[TB] FAIL reset_op_code got %h exp 0", op_code); end
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_req got %b exp 1", imem_req); end
                checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL b2b_first_addr got %h exp 0", imem_addr); end
            end else begin
                checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid cycle %0d got %b exp 1", i, instr_valid); end
                checks++; if (instr_pc !== 32'((i - 1) * 4)) begin errors++; $display("[TB] FAIL b2b_pc cycle %0d got %h exp %h", i, instr_pc, 32'((i - 1) * 4)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int  acks;
        bit  found;
        acks  = 0;
        found = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1'b0, 1'b0, 32'h0);
            if (imem_req && imem_ack) acks++;
        end
        // stray acks while nothing is requested must be ignored
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1'b0, 1'b0, 32'h0);
        end
        checks++; if (acks !== 4) begin errors++; $display("[TB] FAIL full_ack_count got %0d exp 4", acks); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid got %b exp 1", instr_valid); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("[TB] FAIL full_head_pc got %h exp 0", instr_pc); end
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 32'h0);
            if (imem_req) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL resume_req got %b exp 1", found); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL resume_addr got %h exp 10", imem_addr); end
        for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        do_reset();
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 32'h103);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL redir_pending_addr got %h exp 8", imem_addr); end
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL drain_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL drain_addr got %h exp 8", imem_addr); end
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL drain_done_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_dropped got %b exp 0", instr_valid); end
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_new_addr got %h exp 100", imem_addr); end
        // ack coincident with redirect: straight to IDLE, no drain
        applyStimulus(1, 1'b0, 1'b1, 32'h200);
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL coinc_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL coinc_dropped got %b exp 0", instr_valid); end
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL coinc_addr got %h exp 200", imem_addr); end
        for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b exp 0", instr_valid); end
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midrst_refetch got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midrst_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ack_ignored got %b exp 0", instr_valid); end
        for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 120; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 1 : 0, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0), $urandom);
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 1'b0, 32'h0);
        checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL rand_leftover got %0d exp 0", exp_q.size()); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_empty got %b exp 0", instr_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4];
        int          n;
        n = 0;
        exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        @(posedge clk);
        #2;
        w_rst_n = 1'b0; w_ack = 1'b0; w_ready = 1'b1;
        @(posedge clk);
        #2;
        w_rst_n = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(posedge clk);
            #2;
            w_ack   = w_req;
            w_rdata = w_addr;
            if (w_ack) begin
                checks++;
                if (w_addr !== exp_w[n]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr %0d got %h exp %h", n, w_addr, exp_w[n]);
                end
                n++;
            end
        end
        checks++; if (n !== 4) begin errors++; $display("[TB] FAIL wrap_count got %0d exp 4", n); end
        @(posedge clk);
        #2;
        w_ack = 1'b0;
    endtask

`ifdef FETCH_PREDECODE_EN
    task automatic test_predecode();
        do_reset();
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (head_is_jump !== 1'b1) begin errors++; $display("[TB] FAIL pd_jump got %b exp 1", head_is_jump); end
        checks++; if (head_is_branch !== 1'b0) begin errors++; $display("[TB] FAIL pd_jump_branch got %b exp 0", head_is_branch); end
        applyStimulus(0, 1'b1, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b0, 32'h0);
        checks++; if (head_is_branch !== 1'b1) begin errors++; $display("[TB] FAIL pd_branch got %b exp 1", head_is_branch); end
        checks++; if (head_is_jump !== 1'b0) begin errors++; $display("[TB] FAIL pd_branch_jump got %b exp 0", head_is_jump); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        w_rst_n = 1'b0; w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_redirect();
        test_reset_mid();
        test_wrap();
`ifdef FETCH_PREDECODE_EN
        test_predecode();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish, got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
